rob_commit: RTL

- Reorder buffer and in-order commit stage.
- Accepts allocations from the rename stage, collects completion writebacks from execution units, and retires instructions in program order.
- On retirement it returns register-free information to the rename stage (commit_v / commit_rename / mispredict) and releases stores to the store buffer.
- Sits between rename/issue and the architectural state: it is the receiving end of rename_rob and the driving end of commit_rename.

---
 rtl/rob_commit_pkg.sv | 44 ++++
 rtl/rob_commit_ptr_ctrl.sv | 61 ++++++
 rtl/rob_commit.sv | 117 +++++++++++
 3 files changed

// File: rtl/rob_commit_pkg.sv
// Shared types and sizing for the reorder buffer / commit stage.
// Entry layout, commit bundle and writeback bundle live here.
package rob_commit_pkg;

  localparam int ROB_ENTRY    = 16;
  localparam int NUM_PHYS_REG = 32;
  localparam int NUM_ARCH_REG = 8;
  localparam int WORD_SIZE_P  = 16;
  localparam int FLAG_WIDTH   = 4;

  localparam int IDX_W  = $clog2(ROB_ENTRY);
  localparam int CNT_W  = IDX_W + 1;
  localparam int PHYS_W = $clog2(NUM_PHYS_REG);
  localparam int ARCH_W = $clog2(NUM_ARCH_REG);

  typedef struct packed {
    logic                   valid;
    logic                   wb;
    logic                   is_spec;
    logic                   is_store;
    logic                   w_v;
    logic [ARCH_W-1:0]      alloc_reg;
    logic [PHYS_W-1:0]      freed_reg;
    logic [WORD_SIZE_P-1:0] resolved_pc;
    logic [FLAG_WIDTH-1:0]  flags;
  } rename_rob_t;

  typedef struct packed {
    logic              w_v;
    logic [ARCH_W-1:0] alloc_reg;
    logic [PHYS_W-1:0] freed_reg;
  } commit_rename_t;

  typedef struct packed {
    logic [IDX_W-1:0]       idx;
    logic                   mispredict;
    logic [WORD_SIZE_P-1:0] resolved_pc;
    logic [FLAG_WIDTH-1:0]  flags;
  } rob_wb_t;

  localparam int RENAME_ROB_ENTRY_WIDTH = $bits(rename_rob_t);
  localparam int COMMIT_RENAME_WIDTH    = $bits(commit_rename_t);

endpackage

// File: rtl/rob_commit_ptr_ctrl.sv
// Head/tail/count bookkeeping for the reorder buffer.
// A flush collapses the window to just past the retiring head.
module rob_ptr_ctrl
  import rob_commit_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             alloc_v,
  input  logic             commit_v,
  input  logic             flush,
  output logic [IDX_W-1:0] head,
  output logic [IDX_W-1:0] tail,
  output logic             empty,
  output logic             ready,
  output logic             alloc_fire
);

  logic [IDX_W-1:0] head_q, head_n;
  logic [IDX_W-1:0] tail_q, tail_n;
  logic [CNT_W-1:0] count_q, count_n;

  // Ready depends on registered count only; a commit gives no same-cycle credit.
  assign ready      = (count_q != CNT_W'(ROB_ENTRY));
  assign empty      = (count_q == '0);
  assign alloc_fire = alloc_v & ready & ~flush;
  assign head       = head_q;
  assign tail       = tail_q;

  // Next pointer/count: flush restarts an empty window after the head.
  always_comb begin
    head_n  = head_q;
    tail_n  = tail_q;
    count_n = count_q;
    if (flush) begin
      head_n  = head_q + IDX_W'(1);
      tail_n  = head_q + IDX_W'(1);
      count_n = '0;
    end else begin
      if (commit_v)
        head_n = head_q + IDX_W'(1);
      if (alloc_fire)
        tail_n = tail_q + IDX_W'(1);
      count_n = count_q + CNT_W'(alloc_fire)
              - CNT_W'(commit_v);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_n;
      tail_q  <= tail_n;
      count_q <= count_n;
    end
  end

endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order retirement.
// Collects writebacks and retires the head, flushing on mispredict.
module rob_commit
  import rob_commit_pkg::*;
(
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [RENAME_ROB_ENTRY_WIDTH-1:0] rename_rob_i,
  input  logic                              rename_rob_v_i,
  output logic                              rob_ready_o,
  output logic [IDX_W-1:0]                  rob_num_o,
  input  logic                              wb_v_i,
  input  logic [IDX_W-1:0]                  wb_idx_i,
  input  logic                              wb_mispredict_i,
  input  logic [WORD_SIZE_P-1:0]            wb_resolved_pc_i,
  input  logic [FLAG_WIDTH-1:0]             wb_flags_i,
  output logic                              commit_v_o,
  output logic [COMMIT_RENAME_WIDTH-1:0]    commit_rename_o,
  output logic                              mispredict_o,
  output logic [WORD_SIZE_P-1:0]            redirect_pc_o,
  output logic                              commit_store_v_o
);

  rename_rob_t           entries_q [ROB_ENTRY];
  logic [ROB_ENTRY-1:0]  mp_q;
  logic [IDX_W-1:0]      head;
  logic [IDX_W-1:0]      tail;
  logic                  empty;
  logic                  alloc_fire;
  logic                  flush;
  rob_wb_t               wb;
  rename_rob_t           alloc_entry;
  commit_rename_t        commit_info;

  assign wb = '{idx:         wb_idx_i,
                mispredict:  wb_mispredict_i,
                resolved_pc: wb_resolved_pc_i,
                flags:       wb_flags_i};

  rob_ptr_ctrl u_ptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .alloc_v    (rename_rob_v_i),
    .commit_v   (commit_v_o),
    .flush      (flush),
    .head       (head),
    .tail       (tail),
    .empty      (empty),
    .ready      (rob_ready_o),
    .alloc_fire (alloc_fire)
  );

  assign rob_num_o = tail;

  // New entries start valid and not yet completed.
  always_comb begin
    alloc_entry       = rename_rob_t'(rename_rob_i);
    alloc_entry.wb    = 1'b0;
    alloc_entry.valid = 1'b1;
  end

  // Retirement view of the head entry.
  always_comb begin
    commit_v_o  = ~empty & entries_q[head].wb;
    commit_info = '{w_v:       entries_q[head].w_v,
                    alloc_reg: entries_q[head].alloc_reg,
                    freed_reg: entries_q[head].freed_reg};
    mispredict_o     = commit_v_o & mp_q[head];
    redirect_pc_o    = entries_q[head].resolved_pc;
    commit_store_v_o = commit_v_o & entries_q[head].is_store
                     & ~mispredict_o;
  end

  assign commit_rename_o = commit_info;
  assign flush           = commit_v_o & mispredict_o;

  // Entry storage: allocate at tail, complete by index, retire at head.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ROB_ENTRY; i++)
        entries_q[i] <= '0;
      mp_q <= '0;
    end else if (flush) begin
      for (int i = 0; i < ROB_ENTRY; i++) begin
        entries_q[i].valid <= 1'b0;
        entries_q[i].wb    <= 1'b0;
      end
      mp_q <= '0;
    end else begin
      if (alloc_fire) begin
        entries_q[tail] <= alloc_entry;
        mp_q[tail]      <= 1'b0;
      end
      if (wb_v_i && entries_q[wb.idx].valid) begin
        entries_q[wb.idx].wb          <= 1'b1;
        entries_q[wb.idx].flags       <= wb.flags;
        entries_q[wb.idx].resolved_pc <= wb.resolved_pc;
        mp_q[wb.idx] <= wb.mispredict
                      & entries_q[wb.idx].is_spec;
      end
      if (commit_v_o) begin
        entries_q[head].valid <= 1'b0;
        entries_q[head].wb    <= 1'b0;
      end
    end
  end

  // Protocol checks on the rename and writeback sides.
  a_alloc_ready : assert property (
    @(posedge clk_i) disable iff (reset_i)
    rename_rob_v_i |-> rob_ready_o);

  a_wb_valid : assert property (
    @(posedge clk_i) disable iff (reset_i)
    wb_v_i |-> entries_q[wb_idx_i].valid);

endmodule
